e203_icb_sram_rsp: RTL
======================

// Module: e203_icb_sram_rsp
// PURPOSE
// - ICB responder (target) end of the sysper/sysfio/sysmem ICB ports of e203_subsys_top.
// - Replaces the cmd_valid->rsp_valid loopback stub at SoC top with a real word-addressed SRAM target.
// - Accepts cmd, performs byte-masked write or read, and returns in-order responses through an
//   OUTS-deep response FIFO, so the initiator can pipeline requests.
// PARAMETERS
// - AW         32             ICB address width
// - BASE_ADDR  32'h8000_0000  byte address of word 0
// - DEPTH      256            memory size in 32-bit words; power of 2, >=2
// - OUTS       2              response FIFO depth = max outstanding responses; >=1
// PORTS
// - clk            in   1    single clock; all logic is rising-edge
// - rst            in   1    synchronous, active-high reset
// - icb_cmd_valid  in   1    command valid
// - icb_cmd_ready  out  1    command accepted when valid&ready
// - icb_cmd_addr   in   AW   byte address; bits [1:0] ignored
// - icb_cmd_read   in   1    1=read, 0=write
// - icb_cmd_wdata  in   32   write data
// - icb_cmd_wmask  in   4    byte enables; bit i -> wdata[8i+7:8i]
// - icb_rsp_valid  out  1    response valid
// - icb_rsp_ready  in   1    response consumed when valid&ready
// - icb_rsp_err    out  1    access error
// - icb_rsp_rdata  out  32   read data; 32'h0 for writes and errored accesses
// BEHAVIOUR
// - Reset (rst=1 at an edge): FIFO empty; rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_ready=1.
//   Memory contents NOT reset. Reset mid-transaction drops all queued responses.
// - cmd_ready = (fifo count < OUTS), registered state only; no combinational path from rsp_ready.
// - Accept cycle: word index = (addr - BASE_ADDR) >> 2.
//   Write: bytes with wmask=1 updated at that edge; wmask=0 -> no change, still responds.
//   Read: memory word captured at that edge into the FIFO entry {err, rdata}.
// - Latency: rsp_valid rises the cycle after acceptance (1 cycle min); strictly in order.
// - Back-to-back: write A then read A next cycle returns the newly written data.
// - FIFO: push on accept, pop on rsp_valid&rsp_ready; push+pop same cycle keeps count.
//   Full: cmd_ready=0; a pop frees a slot, cmd_ready rises the following cycle.
//   Empty: rsp_valid=0, rsp_rdata/err hold 0. Pointers wrap modulo OUTS.
// - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
// - Count width = clog2(OUTS+1); index width = clog2(DEPTH); subtraction done in AW bits.
// CONFIGURATION
// - Macro E203_ICB_RSP_ERR_EN:
//   defined: range check BASE_ADDR <= addr < BASE_ADDR+4*DEPTH; out of range -> write
//   suppressed, rsp_err=1, rsp_rdata=0; still consumes one FIFO slot and 1-cycle latency.
//   undefined: no range check; word index = low clog2(DEPTH) bits (aliasing); rsp_err always 0.
// TESTING
// - Write 0xDEADBEEF mask 4'hF @BASE, then read @BASE -> rsp_rdata=0xDEADBEEF, err=0, 1 cycle later.
// - Write 0x11223344 mask 4'b0101 over 0xAABBCCDD @BASE+4 -> read returns 0xAA22CC44.
// - OUTS=2, rsp_ready=0, issue 3 reads -> 2 accepted, cmd_ready=0; raise rsp_ready 1 cycle
//   -> one pop, cmd_ready=1 next cycle, 3rd read accepted; order preserved.
// - Streaming: valid=1 and rsp_ready=1 every cycle for 16 reads -> 1 response/cycle, no bubbles.
// - ERR_EN defined: read @BASE+4*DEPTH -> err=1, rdata=0; write there leaves word 0 unchanged.
//   Undefined: same write aliases to word 0, err=0.
// - Assert rst with 2 responses queued -> next cycle rsp_valid=0, cmd_ready=1; memory data retained.

Source files
------------

// File: rtl/e203_icb_sram_rsp.sv
// -----------------------------------------------------------------------------
// e203_icb_sram_rsp
// ICB target backed by a word-addressed SRAM. It accepts one command per cycle,
// performs a byte-masked write or a full-word read, and returns in-order
// responses through an OUTS-deep response FIFO so the initiator can pipeline.
//
// Optional build macro: E203_ICB_RSP_ERR_EN
//   defined   - addresses outside [BASE_ADDR, BASE_ADDR+4*DEPTH) are rejected:
//               the write is dropped, and the response has rsp_err=1, rdata=0.
//   undefined - no range check; the low clog2(DEPTH) word-index bits select the
//               word (aliasing) and rsp_err is always 0.
//
// Ports
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   icb_cmd_valid/ready   command handshake (ready depends on FIFO occupancy only)
//   icb_cmd_addr          byte address, bits [1:0] ignored
//   icb_cmd_read          1 = read, 0 = write
//   icb_cmd_wdata/wmask   write data and byte enables (bit i -> wdata[8i+7:8i])
//   icb_rsp_valid/ready   response handshake
//   icb_rsp_err           access error
//   icb_rsp_rdata         read data, zero for writes, errors and an empty FIFO
// -----------------------------------------------------------------------------
module e203_icb_sram_rsp #(
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000,
    parameter int              DEPTH     = 256,
    parameter int              OUTS      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic [AW-1:0] icb_cmd_addr,
    input  logic          icb_cmd_read,
    input  logic [31:0]   icb_cmd_wdata,
    input  logic [3:0]    icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic          icb_rsp_err,
    output logic [31:0]   icb_rsp_rdata
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(OUTS + 1);
    localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;

    // Wrap a FIFO pointer modulo OUTS (OUTS need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(OUTS - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic [31:0]   mem_r  [DEPTH];
    logic [32:0]   fifo_r [OUTS];      // {err, rdata}

    logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_pop_s;
    logic [PW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic          cmd_ready_r, rsp_valid_r;
    logic [32:0]   head_r, head_nxt_s;

    logic          accept_s, pop_s, in_range_s, wr_en_s;
    logic [AW-1:0] offset_s;
    logic [IW-1:0] idx_s;
    logic [32:0]   push_entry_s;
    logic          addr_unused_s;

    assign accept_s = icb_cmd_valid & cmd_ready_r;
    assign pop_s    = rsp_valid_r & icb_rsp_ready;

    // Subtraction in AW bits: an address below BASE_ADDR wraps to a huge offset.
    assign offset_s = icb_cmd_addr - BASE_ADDR;
    assign idx_s    = offset_s[IW+1:2];

`ifdef E203_ICB_RSP_ERR_EN
    assign in_range_s    = ({2'b00, offset_s[AW-1:2]} < AW'(DEPTH));
    assign addr_unused_s = ^offset_s[1:0];
`else
    assign in_range_s    = 1'b1;
    assign addr_unused_s = ^{offset_s[1:0], offset_s[AW-1:IW+2]};
`endif

    assign wr_en_s = accept_s & ~icb_cmd_read & in_range_s & ~rst;

    // Read data is captured from the array in the accept cycle itself.
    assign push_entry_s = {~in_range_s,
                           (icb_cmd_read & in_range_s) ? mem_r[idx_s] : 32'h0000_0000};

    // Next FIFO occupancy, pointers and the response head that will be visible.
    always_comb begin
        cnt_nxt_s    = cnt_r;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        cnt_pop_s    = cnt_r;
        head_nxt_s   = 33'h0_0000_0000;

        if (accept_s && !pop_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else if (!accept_s && pop_s) begin
            cnt_nxt_s = cnt_r - CW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
            cnt_pop_s    = cnt_r - CW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
            cnt_pop_s    = cnt_r;
        end

        if (accept_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        // If nothing older survives the pop, the new head is the entry being pushed.
        if (cnt_nxt_s == CW'(0)) begin
            head_nxt_s = 33'h0_0000_0000;
        end else if (cnt_pop_s == CW'(0)) begin
            head_nxt_s = push_entry_s;
        end else begin
            head_nxt_s = fifo_r[rd_ptr_nxt_s];
        end
    end

    // FIFO control state and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= CW'(0);
            rd_ptr_r    <= PW'(0);
            wr_ptr_r    <= PW'(0);
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            head_r      <= 33'h0_0000_0000;
        end else begin
            cnt_r       <= cnt_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            cmd_ready_r <= (cnt_nxt_s < CW'(OUTS));
            rsp_valid_r <= (cnt_nxt_s != CW'(0));
            head_r      <= head_nxt_s;
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            fifo_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // SRAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && icb_cmd_wmask[i]) begin
                mem_r[idx_s][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
            end
        end
    end

    assign icb_cmd_ready = cmd_ready_r;
    assign icb_rsp_valid = rsp_valid_r;
    assign icb_rsp_err   = head_r[32];
    assign icb_rsp_rdata = head_r[31:0];

endmodule
